// File: rtl/segshift_rx.sv
// segshift_rx -- receiving end of the seven-segment serial display link.
// Deserializes the MSB-first segment stream (shiftIn/shiftClk), and on each
// latchIn rising edge decodes every 8-bit segment byte back to a BCD digit.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   shiftIn    serial segment data, sampled on shiftClk rising edge
//   shiftClk   serial shift clock (asynchronous to clk)
//   latchIn    latch strobe, rising edge ends a frame
//   cnt_out    decoded BCD value, digit 0 in [3:0]
//   segRaw     raw latched segment bytes, digit 0 in [7:0]
//   digitErr   per-digit flag: latched byte is not a legal pattern
//   frameValid one-cycle pulse: cnt_out/segRaw/digitErr updated
//   frameErr   one-cycle pulse: latch seen with wrong bit count
module segshift_rx #(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    shiftIn,
  input  logic                    shiftClk,
  input  logic                    latchIn,
  output logic [4*NUM_DIGITS-1:0] cnt_out,
  output logic [8*NUM_DIGITS-1:0] segRaw,
  output logic [NUM_DIGITS-1:0]   digitErr,
  output logic                    frameValid,
  output logic                    frameErr
);

  localparam int FW = 8 * NUM_DIGITS;
  localparam int CW = $clog2(FW + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

  logic [SYNC_STAGES-1:0] sh_sync, ck_sync, la_sync;
  logic                   ck_prev, la_prev;
  logic                   sh_bit, ck_rise, la_rise;

  logic [FW-1:0]           sr, sr_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [4*NUM_DIGITS-1:0] dec_cnt;
  logic [NUM_DIGITS-1:0]   dec_err;

  // Returns {err, nibble}; dp (bit 7) is ignored by the caller.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h00:   decode = 5'h0F;
      default: decode = 5'h1E;
    endcase
  endfunction

  assign sh_bit  = sh_sync[SYNC_STAGES-1];
  assign ck_rise = ck_sync[SYNC_STAGES-1] & ~ck_prev;
  assign la_rise = la_sync[SYNC_STAGES-1] & ~la_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_sync <= '0;
      ck_sync <= '0;
      la_sync <= '0;
      ck_prev <= 1'b0;
      la_prev <= 1'b0;
    end else begin
      sh_sync <= {sh_sync[SYNC_STAGES-2:0], shiftIn};
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], shiftClk};
      la_sync <= {la_sync[SYNC_STAGES-2:0], latchIn};
      ck_prev <= ck_sync[SYNC_STAGES-1];
      la_prev <= la_sync[SYNC_STAGES-1];
    end
  end

  // Shift is resolved combinationally so a latch detected in the same cycle
  // sees the post-shift register and count.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    if (ck_rise) begin
      sr_next = {sr[FW-2:0], sh_bit};
      if (cnt != CNT_SAT) cnt_next = cnt + CW'(1);
    end
  end

  always_comb begin
    dec_cnt = '0;
    dec_err = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      logic [4:0] d;
      d = decode(sr_next[8*i +: 7]);
      dec_cnt[4*i +: 4] = d[3:0];
      dec_err[i]        = d[4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      cnt        <= '0;
      cnt_out    <= '0;
      segRaw     <= '0;
      digitErr   <= '0;
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      sr         <= sr_next;
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
      if (la_rise) begin
        cnt <= '0;
        if (cnt_next == CNT_FULL) begin
          segRaw     <= sr_next;
          cnt_out    <= dec_cnt;
          digitErr   <= dec_err;
          frameValid <= 1'b1;
        end else begin
          frameErr <= 1'b1;
        end
      end else begin
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_segshift_rx.sv
module tb_segshift_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        shiftIn, shiftClk, latchIn;
  logic [23:0] cnt_out;
  logic [47:0] segRaw;
  logic [5:0]  digitErr;
  logic        frameValid, frameErr;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        valid;
    logic [23:0] cnt;
    logic [47:0] seg;
    logic [5:0]  derr;
  } exp_t;

  exp_t exp_q[$];
  logic [23:0] last_cnt;
  logic [47:0] last_seg;
  logic [5:0]  last_derr;

  always #5 clk = ~clk;

  segshift_rx #(.NUM_DIGITS(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .shiftIn(shiftIn), .shiftClk(shiftClk),
    .latchIn(latchIn), .cnt_out(cnt_out), .segRaw(segRaw),
    .digitErr(digitErr), .frameValid(frameValid), .frameErr(frameErr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse pops one expected response.
  always @(negedge clk) begin
    if (frameValid || frameErr) begin
      check("pulse_exclusive", 64'(frameValid & frameErr), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {62'd0, frameValid, frameErr}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {62'd0, frameValid, frameErr}, {62'd0, e.valid, ~e.valid});
        check("cnt_out", 64'(cnt_out), 64'(e.cnt));
        check("segRaw", 64'(segRaw), 64'(e.seg));
        check("digitErr", 64'(digitErr), 64'(e.derr));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    shiftIn = b;
    wait_cyc(4);
    shiftClk = 1'b1;
    wait_cyc(4);
    shiftClk = 1'b0;
  endtask

  // Shifts the first n bits of f, MSB first.
  task automatic shift_bits(input logic [47:0] f, input int n);
    for (int i = 47; i > 47 - n; i--) shift_bit(f[i]);
  endtask

  task automatic latch();
    latchIn = 1'b1;
    wait_cyc(4);
    latchIn = 1'b0;
    wait_cyc(4);
  endtask

  task automatic push_valid(input logic [47:0] f, input logic [23:0] c, input logic [5:0] d);
    exp_t e;
    e.valid = 1'b1; e.cnt = c; e.seg = f; e.derr = d;
    exp_q.push_back(e);
    last_cnt = c; last_seg = f; last_derr = d;
  endtask

  task automatic push_err();
    exp_t e;
    e.valid = 1'b0; e.cnt = last_cnt; e.seg = last_seg; e.derr = last_derr;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt"},   64'(cnt_out), 64'd0);
    check({tag, "_seg"},   64'(segRaw), 64'd0);
    check({tag, "_derr"},  64'(digitErr), 64'd0);
    check({tag, "_pulse"}, {62'd0, frameValid, frameErr}, 64'd0);
  endtask

  task automatic full_frame(input logic [47:0] f, input logic [23:0] c, input logic [5:0] d);
    shift_bits(f, 48);
    push_valid(f, c, d);
    latch();
  endtask

  localparam logic [47:0] F1 = 48'h7D6D664F5B06;  // 654321
  localparam logic [47:0] F2 = 48'h0086493F3F3F;  // blank, 1+dp, illegal, 0,0,0
  localparam logic [47:0] F3 = 48'h6F7F073F6D5B;  // 987052
  localparam logic [47:0] F4 = 48'h065B4F666D7D;  // 123456
  localparam logic [47:0] F5 = 48'hFF00807F7708;  // 8+dp, blank, dp-only, 8, illegal, illegal

  initial begin
    last_cnt = '0; last_seg = '0; last_derr = '0;
    reset = 1'b1; shiftIn = 1'b0; shiftClk = 1'b0; latchIn = 1'b0;

    // Reset with random activity on the inputs.
    for (int i = 0; i < 6; i++) begin
      shiftIn  = 1'($urandom_range(0, 1));
      shiftClk = 1'($urandom_range(0, 1));
      latchIn  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i == 5) check_zero("in_reset");
    end
    shiftIn = 1'b0; shiftClk = 1'b0; latchIn = 1'b0;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(6);
    check_zero("after_reset");

    full_frame(F1, 24'h654321, 6'b000000);

    // Length errors: 47, 49 and 0 bits; outputs must hold.
    shift_bits(F2, 47);
    push_err();
    latch();
    shift_bits(F2, 48);
    shift_bit(1'b1);
    push_err();
    latch();
    push_err();
    latch();

    full_frame(F2, 24'hF1E000, 6'b001000);
    full_frame(F5, 24'h8FF8EE, 6'b000011);

    // 48th shift edge coincident with the latch edge.
    shift_bits(F3, 47);
    shiftIn = F3[0];
    wait_cyc(4);
    push_valid(F3, 24'h987052, 6'b000000);
    shiftClk = 1'b1;
    latchIn  = 1'b1;
    wait_cyc(4);
    shiftClk = 1'b0;
    latchIn  = 1'b0;
    wait_cyc(4);

    // Reset mid-frame discards the partial frame.
    shift_bits(F1, 20);
    reset = 1'b1;
    wait_cyc(2);
    check_zero("midframe_reset");
    reset = 1'b0;
    last_cnt = '0; last_seg = '0; last_derr = '0;
    wait_cyc(2);
    full_frame(F4, 24'h123456, 6'b000000);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_expected", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
